// File: rtl/uart_echo_fifo.sv
// UART echo controller: buffers received words in a DEPTH-entry FIFO and replays them to the
// transmitter in order. Define UART_ECHO_ERR_SUB_EN to echo SUB_CHAR for errored frames.
module uart_echo_fifo #(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16,
  parameter int                ACK_TIMEOUT = 4,
  parameter logic [DATA_W-1:0] SUB_CHAR    = 8'h3F
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_done,
  input  logic                       rx_error,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     ack_cnt;
  logic              push_req;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_word;

`ifdef UART_ECHO_ERR_SUB_EN
  assign push_req = rx_done;
`else
  assign push_req = rx_done & ~rx_error;
`endif
  // In the default build an errored frame never reaches the FIFO, so the mux is harmless there.
  assign push_word  = rx_error ? SUB_CHAR : rx_data;

  assign fifo_count = count;
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  // A pop frees a slot in the same edge, so a full FIFO can still accept a word while launching one.
  assign pop  = (state == IDLE) && !fifo_empty && !tx_busy;
  assign push = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ack_cnt  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && fifo_full && !pop;
      tx_start <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            ack_cnt  <= '0;
            state    <= WAIT_ACK;
          end
        end
        // A transmitter that never acknowledges must not stall the queue forever.
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: directed scenarios plus randomized traffic checked
// each cycle against a queue-based reference model and a tx_busy history.
module tb_uart_echo_fifo;

  localparam int         DATA_W      = 8;
  localparam int         DEPTH       = 16;
  localparam int         ACK_TIMEOUT = 4;
  localparam logic [7:0] SUB_CHAR    = 8'h3F;
  localparam int         CW          = $clog2(DEPTH) + 1;
  localparam int         MAXC        = 8192;
`ifdef UART_ECHO_ERR_SUB_EN
  localparam bit ERR_SUB = 1'b1;
`else
  localparam bit ERR_SUB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              rx_error;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  always #5 clk = ~clk;

  uart_echo_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .SUB_CHAR(SUB_CHAR)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: words waiting, plus the history of tx_busy since the last launch.
  logic [7:0] mq[$];
  bit         busy_hist [MAXC];
  bit         launched;
  int         launch_at;
  logic [7:0] exp_data;
  bit         exp_start;
  bit         exp_ovf;

  // The controller can launch again once the handshake for the last word is over: either
  // no acknowledge within ACK_TIMEOUT cycles of tx_start, or tx_busy rose and later fell.
  function automatic bit model_idle(input int c);
    int ack;
    if (!launched) return 1'b1;
    ack = -1;
    for (int k = 0; k < ACK_TIMEOUT; k++) begin
      if (launch_at + k >= c) return 1'b0;
      if (busy_hist[launch_at + k]) begin
        ack = launch_at + k;
        break;
      end
    end
    if (ack < 0) return 1'b1;
    for (int d = ack + 1; d < c; d++)
      if (!busy_hist[d]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    bit         pop;
    bit         req;
    logic [7:0] w;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    busy_hist[cyc] = tx_busy;
    if (rst) begin
      mq.delete();
      launched  = 1'b0;
      exp_data  = '0;
      exp_start = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      pop       = model_idle(cyc) && (mq.size() > 0) && !tx_busy;
      req       = rx_done && (!rx_error || ERR_SUB);
      w         = rx_error ? SUB_CHAR : rx_data;
      exp_start = pop;
      exp_ovf   = 1'b0;
      if (pop) begin
        exp_data  = mq.pop_front();
        launched  = 1'b1;
        launch_at = cyc + 1;
      end
      if (req) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("tx_start",   tx_start,   exp_start);
    check("tx_data",    tx_data,    exp_data);
    check("overflow",   overflow,   exp_ovf);
    check("fifo_count", fifo_count, mq.size());
    check("fifo_full",  fifo_full,  mq.size() == DEPTH);
    check("fifo_empty", fifo_empty, mq.size() == 0);
  endtask

  // Transmitter stand-in: 0 answers tx_start with a busy burst, 1 holds busy, 2 never goes busy.
  int tx_mode   = 0;
  int busy_left = 0;
  int fixed_len = 0;

  task automatic tick(input bit d, input logic [7:0] data, input bit err, input bit r = 1'b0);
    rst      = r;
    rx_done  = d;
    rx_data  = data;
    rx_error = err;
    case (tx_mode)
      1:       tx_busy = 1'b1;
      2:       tx_busy = 1'b0;
      default: begin
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
    endcase
    step();
    if (tx_mode == 0 && tx_start)
      busy_left = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 10));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = '0; rx_error = 1'b0; tx_busy = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Single echo with a 10-cycle transmitter.
    fixed_len = 10;
    tick(1'b1, 8'hA5, 1'b0);
    idle(1);
    check("echo_latency", tx_start, 1'b1);
    check("echo_data", tx_data, 8'hA5);
    idle(20);
    fixed_len = 0;

    // Burst while the transmitter is held busy, then drain.
    tx_mode = 1;
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0);
    check("burst_count", fifo_count, 5);
    tx_mode = 0;
    idle(80);

    // Overflow: 17 pushes into a 16-entry FIFO.
    tx_mode = 1;
    for (int i = 0; i < 17; i++) tick(1'b1, 8'(8'h40 + i), 1'b0);
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_full", fifo_full, 1'b1);
    idle(1);

    // Push and pop in the same cycle at full.
    tx_mode = 2;
    tick(1'b1, 8'hEE, 1'b0);
    check("simul_count", fifo_count, DEPTH);
    check("simul_ovf", overflow, 1'b0);
    tx_mode = 0;
    idle(300);

    // Pointer wrap with interleaved push/drain.
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(8'h80 + i), 1'b0);
      idle(2);
    end
    idle(300);

    // Errored frame.
    tick(1'b1, 8'h55, 1'b1);
    idle(20);

    // Acknowledge timeout: transmitter never goes busy.
    tx_mode = 2;
    tick(1'b1, 8'h71, 1'b0);
    tick(1'b1, 8'h72, 1'b0);
    idle(15);

    // Reset while a word is in flight and others are buffered.
    tx_mode = 0;
    fixed_len = 10;
    tick(1'b1, 8'hC1, 1'b0);
    tick(1'b1, 8'hC2, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    tick(1'b1, 8'hC4, 1'b0);
    idle(3);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_count", fifo_count, 0);
    check("rst_start", tx_start, 1'b0);
    idle(20);
    fixed_len = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 5))
          0:       tx_mode = 1;
          1:       tx_mode = 2;
          default: tx_mode = 0;
        endcase
      end
      tick(($urandom_range(0, 99) < 35), 8'($urandom), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 599) == 0));
    end
    tx_mode = 0;
    idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised successor to the single-byte UART echo controller. It buffers every good received word in a DEPTH-entry FIFO and replays the words to the transmitter in order. Each word goes out through a tx_start pulse and a full tx_busy handshake. It sits between uart_rx and uart_tx in the integrated loopback top, so back-to-back RX frames are no longer lost while TX is busy.

Parameters:
DATA_W, 8, width of rx_data/tx_data
DEPTH, 16, FIFO entries; power of two, >= 2
ACK_TIMEOUT, 4, max cycles in WAIT_ACK for tx_busy to rise before abandoning the handshake; >= 1
SUB_CHAR, 8'h3F, substitute word for errored frames (used only with optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rx_data  input  DATA_W  received word, valid when rx_done=1
rx_done  input  1  one-cycle pulse, frame received
rx_error  input  1  qualifies rx_done; frame/parity error
tx_data  output  DATA_W  word to transmit, stable from tx_start until next load
tx_start  output  1  one-cycle transmit request
tx_busy  input  1  transmitter busy
fifo_count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
fifo_full  output  1  fifo_count==DEPTH
fifo_empty  output  1  fifo_count==0
overflow  output  1  one-cycle pulse, word dropped because FIFO full

Behaviour:
- Reset (rst=1 at an edge): tx_data=0, tx_start=0, overflow=0, fifo_count=0, fifo_empty=1, fifo_full=0, pointers=0, state=IDLE. Reset mid-transfer discards all buffered words and the in-flight handshake; tx_start never asserts in the cycle after reset.
- Push: when rx_done=1 and rx_error=0, and (not full, or a pop occurs the same cycle), rx_data is written at the write pointer at that edge. Write pointer wraps DEPTH-1 -> 0.
- Errored frame (rx_done=1, rx_error=1): ignored, no push, no overflow.
- Full drop: a push request while full with no same-cycle pop -> word discarded, overflow=1 for the next cycle only, FIFO unchanged.
- Count: push only -> +1; pop only -> -1; push and pop together -> unchanged. fifo_full and fifo_empty are registered or derived from the count, consistent in the same cycle.
- FSM (3 states):
  IDLE: if fifo_empty=0 and tx_busy=0 -> tx_data<=head, pop (read pointer +1, wraps), tx_start<=1, go WAIT_ACK. Otherwise stay.
  WAIT_ACK: tx_start=0 (exactly one-cycle pulse). If tx_busy=1 -> WAIT_DONE. Else count cycles; after ACK_TIMEOUT cycles without tx_busy -> IDLE (word treated as sent, not re-queued).
  WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> IDLE.
- Latency: rx_done in cycle 0 into an empty FIFO with TX idle -> fifo_count=1 in cycle 1 -> tx_start=1 in cycle 2 with tx_data valid.
- Minimum spacing between tx_start pulses is 3 cycles (IDLE->WAIT_ACK->WAIT_DONE->IDLE).
- Ordering is strict FIFO. No word is sent twice or skipped except by full-drop.

Optional Feature:
Macro UART_ECHO_ERR_SUB_EN.
- Defined: rx_done=1 with rx_error=1 pushes SUB_CHAR instead of being ignored. It follows the same full/overflow rules as a good word.
- Undefined: errored frames are silently ignored, as described above. Ports are identical either way.

Test Plan:
- Single echo: rx_data=8'hA5 with rx_done in cycle 0, tx_busy=0 -> tx_start=1 in cycle 2, tx_data=8'hA5; model raises tx_busy for 10 cycles; fifo_count returns to 0.
- Burst ordering: push 8'h01..8'h05 on consecutive cycles while tx_busy=1 -> fifo_count=5. Release tx_busy -> tx_data sequence 01,02,03,04,05, one tx_start per handshake.
- Overflow/wrap: DEPTH=16, push 17 words while tx_busy=1 -> fifo_full=1 after the 16th, overflow pulses once on the 17th. After draining, the 16 sent words match pushes 1..16. A further 20-word push/drain crosses the pointer wrap with correct order.
- Simultaneous push/pop at full: FIFO full, IDLE pop and rx_done in the same cycle -> new word accepted, fifo_count stays 16, no overflow.
- Error and timeout: rx_done with rx_error=1, rx_data=8'h55 -> no push (macro off) or 8'h3F echoed (macro on). Separately, tx_busy held 0 after tx_start -> FSM back in IDLE after 4 cycles; the next word is launched.
- Reset mid-operation: 3 words buffered, FSM in WAIT_DONE, rst=1 for one cycle -> all outputs at reset values next cycle, fifo_count=0, no tx_start thereafter until a new rx_done.
